pc_unit: RTL and testbench

- Parametrised next-generation program counter for the multi-cycle RV32I core.
- Holds the architectural PC and advances it only when the control FSM strobes `pc_update`.
- Resolves all six branch conditions (signed and unsigned), JAL and JALR.
- Checks target alignment, redirects to a trap vector on a trap request or a misaligned target, and keeps a retired-instruction counter.
- Sits between the control FSM, the register file read ports and the ALU, which supplies the branch/jump target.

---
 rtl/rv_pkg.sv | 25 ++
 rtl/pc_unit_if.sv | 31 +++
 rtl/branch_cmp.sv | 28 ++
 rtl/pc_unit.sv | 108 ++++++++++
 tb/tb_pc_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I decode constants and the next-PC source selector.
package rv_pkg;

    // Major opcodes the PC unit cares about
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    // Branch funct3 encodings (010/011 are reserved)
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Source of the next architectural PC
    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_TGT,
        NPC_TRAP
    } next_pc_sel_t;

endpackage

// File: rtl/pc_unit_if.sv
// Bus between the control FSM / datapath and the PC unit.
interface pc_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic             pc_update;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [XLEN-1:0]  rs1v;
    logic [XLEN-1:0]  rs2v;
    logic [XLEN-1:0]  alu_output;
    logic             trap_req;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  old_pc;
    logic [XLEN-1:0]  pc_plus;
    logic             take;
    logic             misaligned;
    logic [CNT_W-1:0] retired;

    // Control side: drives the instruction context, observes the PC state
    modport master (
        output pc_update, opcode, func3, rs1v, rs2v, alu_output, trap_req,
        input  pc, old_pc, pc_plus, take, misaligned, retired
    );

    // PC unit side
    modport slave (
        input  pc_update, opcode, func3, rs1v, rs2v, alu_output, trap_req,
        output pc, old_pc, pc_plus, take, misaligned, retired
    );
endinterface

// File: rtl/branch_cmp.sv
// Branch condition evaluator: purely combinational, shared with the decoder.
module branch_cmp
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] rs1v,
    input  logic [XLEN-1:0] rs2v,
    output logic            cond
);

    // Resolve the six branch conditions; reserved encodings never take
    always_comb begin
        // NOTE: assign a default first so no path through the case leaves cond unassigned (no latch).
        cond = 1'b0;
        unique case (func3)
            F3_BEQ:  cond = (rs1v == rs2v);
            F3_BNE:  cond = (rs1v != rs2v);
            F3_BLT:  cond = ($signed(rs1v) <  $signed(rs2v));
            F3_BGE:  cond = ($signed(rs1v) >= $signed(rs2v));
            F3_BLTU: cond = (rs1v <  rs2v);
            F3_BGEU: cond = (rs1v >= rs2v);
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter for the multi-cycle RV32I core: branch/jump resolution,
// target alignment check, trap redirect and retired-instruction counter.
module pc_unit
    import rv_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              IALIGN       = 4,
    parameter int              CNT_W        = 64
) (
    input logic      clk,
    input logic      rst_n,
    pc_unit_if.slave bus
);

    localparam logic [XLEN-1:0] STEP       = XLEN'(IALIGN);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  old_pc_q;
    logic             misaligned_q;
    logic [CNT_W-1:0] retired_q;

    logic             cond;
    logic             take;
    logic             tgt_misaligned;
    logic [XLEN-1:0]  tgt;
    logic [XLEN-1:0]  pc_plus;
    logic [XLEN-1:0]  pc_next;
    next_pc_sel_t     sel;

    branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
        .func3 (bus.func3),
        .rs1v  (bus.rs1v),
        .rs2v  (bus.rs2v),
        .cond  (cond)
    );

    // Sequential successor wraps naturally at 2^XLEN
    assign pc_plus = pc_q + STEP;

    // Decide redirect, effective target and where the next PC comes from
    always_comb begin
        take           = 1'b0;
        tgt            = bus.alu_output;
        tgt_misaligned = 1'b0;
        sel            = NPC_SEQ;
        pc_next        = pc_plus;

        unique case (bus.opcode)
            OP_BRANCH: take = cond;
            OP_JAL:    take = 1'b1;
            OP_JALR: begin
                take   = 1'b1;
                tgt[0] = 1'b0;
            end
            default:   take = 1'b0;
        endcase

        // Only a redirect that is actually taken can fault on alignment
        tgt_misaligned = take && ((tgt & ALIGN_MASK) != '0);

        if (bus.trap_req || tgt_misaligned) begin
            sel = NPC_TRAP;
        end else if (take) begin
            sel = NPC_TGT;
        end

        unique case (sel)
            NPC_TRAP: pc_next = TRAP_VECTOR;
            NPC_TGT:  pc_next = tgt;
            default:  pc_next = pc_plus;
        endcase
    end

    // Commit the next PC, link PC, fault pulse and retire count on a strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= RESET_VECTOR;
            old_pc_q     <= RESET_VECTOR;
            misaligned_q <= 1'b0;
            retired_q    <= '0;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            misaligned_q <= 1'b0;
            if (bus.pc_update) begin
                pc_q     <= pc_next;
                old_pc_q <= pc_q;
                if (bus.trap_req) begin
                    misaligned_q <= 1'b0;
                end else if (tgt_misaligned) begin
                    misaligned_q <= 1'b1;
                end else begin
                    retired_q <= retired_q + 1'b1;
                end
            end
        end
    end

    assign bus.pc         = pc_q;
    assign bus.old_pc     = old_pc_q;
    assign bus.pc_plus    = pc_plus;
    assign bus.take       = take;
    assign bus.misaligned = misaligned_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with hand-computed expectations.
module tb_pc_unit;
    import rv_pkg::*;

    localparam int          XLEN  = 32;
    localparam int          CNT_W = 64;
    localparam logic [31:0] RST_V = 32'h0000_0000;
    localparam logic [31:0] TRP_V = 32'h0000_0100;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    pc_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    pc_unit #(
        .XLEN         (XLEN),
        .RESET_VECTOR (RST_V),
        .TRAP_VECTOR  (TRP_V),
        .IALIGN       (4),
        .CNT_W        (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one instruction context at the falling edge
    task automatic drive(input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] alu, input logic trap);
        @(negedge clk);
        bus.opcode     = op;
        bus.func3      = f3;
        bus.rs1v       = a;
        bus.rs2v       = b;
        bus.alu_output = alu;
        bus.trap_req   = trap;
        #1;
    endtask

    // Commit the currently driven instruction on the next rising edge
    task automatic strobe();
        bus.pc_update = 1'b1;
        @(posedge clk);
        #1;
        bus.pc_update = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.pc_update  = 1'b0;
        bus.opcode     = OP_IMM;
        bus.func3      = 3'b000;
        bus.rs1v       = '0;
        bus.rs2v       = '0;
        bus.alu_output = '0;
        bus.trap_req   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc",      bus.pc, RST_V);
        check("rst_old_pc",  bus.old_pc, RST_V);
        check("rst_mis",     bus.misaligned, 0);
        check("rst_retired", bus.retired, 0);
        check("rst_take",    bus.take, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // pc_update held for three cycles: three sequential commits
        drive(OP_IMM, 3'b000, 0, 0, 32'h10, 1'b0);
        bus.pc_update = 1'b1;
        @(posedge clk); #1; check("seq1_pc", bus.pc, 4);
        @(posedge clk); #1; check("seq2_pc", bus.pc, 8);
        @(posedge clk); #1; check("seq3_pc", bus.pc, 12);
        bus.pc_update = 1'b0;
        check("seq_old_pc",  bus.old_pc, 8);
        check("seq_retired", bus.retired, 3);
        check("seq_pc_plus", bus.pc_plus, 16);

        // Signed vs unsigned less-than on the same operands
        drive(OP_BRANCH, F3_BLT, 32'hFFFF_FFFF, 1, 32'h40, 1'b0);
        check("blt_take", bus.take, 1);
        strobe();
        check("blt_pc",      bus.pc, 32'h40);
        check("blt_old_pc",  bus.old_pc, 12);
        check("blt_retired", bus.retired, 4);
        drive(OP_BRANCH, F3_BLTU, 32'hFFFF_FFFF, 1, 32'h40, 1'b0);
        check("bltu_take", bus.take, 0);
        strobe();
        check("bltu_pc",      bus.pc, 32'h44);
        check("bltu_retired", bus.retired, 5);

        // Remaining conditions, combinational only
        drive(OP_BRANCH, F3_BGE, 32'hFFFF_FFFF, 1, 32'h40, 1'b0);
        check("bge_take", bus.take, 0);
        drive(OP_BRANCH, F3_BGEU, 32'hFFFF_FFFF, 1, 32'h40, 1'b0);
        check("bgeu_take", bus.take, 1);
        drive(OP_BRANCH, F3_BNE, 5, 5, 32'h40, 1'b0);
        check("bne_take", bus.take, 0);
        drive(OP_BRANCH, 3'b010, 5, 5, 32'h40, 1'b0);
        check("rsvd_take", bus.take, 0);
        drive(OP_IMM, F3_BEQ, 5, 5, 32'h40, 1'b0);
        check("nonbr_take", bus.take, 0);

        // JALR clears bit 0 of the target
        drive(OP_JALR, 3'b000, 0, 0, 32'h81, 1'b0);
        strobe();
        check("jalr_pc",      bus.pc, 32'h80);
        check("jalr_old_pc",  bus.old_pc, 32'h44);
        check("jalr_mis",     bus.misaligned, 0);
        check("jalr_retired", bus.retired, 6);

        // JAL to a half-word aligned target traps
        drive(OP_JAL, 3'b000, 0, 0, 32'h82, 1'b0);
        check("jal_take", bus.take, 1);
        strobe();
        check("jal_mis_pc",   bus.pc, TRP_V);
        check("jal_mis",      bus.misaligned, 1);
        check("jal_retired",  bus.retired, 6);
        check("jal_old_pc",   bus.old_pc, 32'h80);
        @(posedge clk); #1;
        check("jal_mis_clr",  bus.misaligned, 0);
        check("jal_pc_hold",  bus.pc, TRP_V);

        // Trap request beats a taken branch
        drive(OP_BRANCH, F3_BEQ, 5, 5, 32'h200, 1'b1);
        check("trap_take", bus.take, 1);
        strobe();
        check("trap_pc",      bus.pc, TRP_V);
        check("trap_mis",     bus.misaligned, 0);
        check("trap_retired", bus.retired, 6);

        // Not-taken branch with a misaligned target does not fault
        drive(OP_BRANCH, F3_BEQ, 5, 6, 32'h3, 1'b0);
        strobe();
        check("nt_pc",      bus.pc, 32'h104);
        check("nt_mis",     bus.misaligned, 0);
        check("nt_retired", bus.retired, 7);

        // Sequential wrap from the top of the address space
        drive(OP_JAL, 3'b000, 0, 0, 32'hFFFF_FFFC, 1'b0);
        strobe();
        check("top_pc",      bus.pc, 32'hFFFF_FFFC);
        check("top_pc_plus", bus.pc_plus, 0);
        drive(OP_IMM, 3'b000, 0, 0, 0, 1'b0);
        strobe();
        check("wrap_pc",      bus.pc, 0);
        check("wrap_old_pc",  bus.old_pc, 32'hFFFF_FFFC);
        check("wrap_retired", bus.retired, 9);

        // Idle: no strobe for ten cycles
        drive(OP_JAL, 3'b000, 0, 0, 32'h300, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        check("idle_pc",      bus.pc, 0);
        check("idle_retired", bus.retired, 9);

        // Asynchronous reset mid-cycle wins over a pending strobe
        drive(OP_IMM, 3'b000, 0, 0, 0, 1'b0);
        strobe();
        check("pre_rst_pc", bus.pc, 4);
        @(negedge clk);
        bus.pc_update = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pc",      bus.pc, RST_V);
        check("arst_old_pc",  bus.old_pc, RST_V);
        check("arst_retired", bus.retired, 0);
        @(posedge clk); #1;
        check("arst_edge_pc",      bus.pc, RST_V);
        check("arst_edge_retired", bus.retired, 0);
        bus.pc_update = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_pc", bus.pc, RST_V);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
